// File: rtl/intel8080_clkrst.sv
// Clock-enable and reset sequencer for an 8080 core running from a 50 MHz system clock.
// Generates phi1/phi2/tick enables per T-state, the CPU/peripheral resets and single-step control.
//
// state       | meaning
// S_RST       | system reset asserted, no enables
// S_HOLD      | T-states running, CPU RESET held for RST_HOLD T-states
// S_RUN       | free-running T-states
// S_STEP_WAIT | parked between T-states until a step request or step mode is cleared
module intel8080_clkrst #(
  parameter int CLK_DIV  = 25,
  parameter int PHI2_POS = 8,
  parameter int RST_HOLD = 4
) (
  input  logic clk50M_i,
  input  logic rst_ni,
  input  logic step_mode_i,
  input  logic step_i,
  output logic phi1_en_o,
  output logic phi2_en_o,
  output logic tick_o,
  output logic cpu_reset_o,
  output logic sys_rstn_o,
  output logic stepping_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int HW = $clog2(RST_HOLD);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] PHI2_CNT  = DW'(PHI2_POS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  typedef enum logic [1:0] {S_RST, S_HOLD, S_RUN, S_STEP_WAIT} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   div_cnt, div_next;
  logic [HW-1:0]   hold_cnt, hold_next;
  logic            step_q;
  logic            active;
  logic            t_end;
  logic            step_pulse;

  always_ff @(posedge clk50M_i) begin
    if (!rst_ni) begin
      state    <= S_RST;
      div_cnt  <= '0;
      hold_cnt <= '0;
      step_q   <= 1'b0;
    end else begin
      state    <= state_next;
      div_cnt  <= div_next;
      hold_cnt <= hold_next;
      step_q   <= step_i;
    end
  end

  always_comb begin
    active     = (state == S_HOLD) || (state == S_RUN);
    t_end      = active && (div_cnt == DIV_LAST);
    // step_q tracks step_i in every state, so a level held across states never re-triggers
    step_pulse = step_i && !step_q;

    state_next = state;
    div_next   = div_cnt;
    hold_next  = hold_cnt;

    case (state)
      S_RST: begin
        state_next = S_HOLD;
        div_next   = '0;
        hold_next  = '0;
      end
      S_HOLD: begin
        div_next = t_end ? '0 : div_cnt + 1'b1;
        if (t_end) begin
          if (hold_cnt == HOLD_LAST) state_next = S_RUN;
          else                       hold_next  = hold_cnt + 1'b1;
        end
      end
      S_RUN: begin
        div_next = t_end ? '0 : div_cnt + 1'b1;
        if (t_end && step_mode_i) state_next = S_STEP_WAIT;
      end
      S_STEP_WAIT: begin
        div_next = '0;
        if (!step_mode_i || step_pulse) state_next = S_RUN;
      end
      default: begin
        state_next = S_RST;
        div_next   = '0;
        hold_next  = '0;
      end
    endcase

    phi1_en_o   = active && (div_cnt == '0);
    phi2_en_o   = active && (div_cnt == PHI2_CNT);
    tick_o      = t_end;
    cpu_reset_o = (state == S_RST) || (state == S_HOLD);
    sys_rstn_o  = (state != S_RST);
    stepping_o  = (state == S_STEP_WAIT);
  end

endmodule
